bus_grant_controller: RTL

Arbiter and sequencer for the shared two-master serial bus. Collects each master's request and 2-bit serially transmitted slave address, and arbitrates fairly (round-robin) between m1 and m2. It holds the bus for the winning master until that master releases it or a hold timeout expires. Its outputs drive the bus mux select lines (bus_grant, slave_sel) and the per-master grant handshakes.

---
 rtl/bus_grant_controller.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/bus_grant_controller.sv
// Round-robin arbiter/sequencer for the shared two-master serial bus.
// Collects each master's serial 2-bit slave address, waits out busy slaves and enforces a hold timeout.
module bus_grant_controller #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       m1_request,
  input  logic       m2_request,
  input  logic       m1_slave_sel,
  input  logic       m2_slave_sel,
  input  logic [2:0] slave_busy,
  output logic       m1_grant,
  output logic       m2_grant,
  output logic [1:0] bus_grant,
  output logic [1:0] slave_sel,
  output logic       arbiter_busy,
  output logic       addr_err,
  output logic       timeout
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ADDR_LO = 3'd1,
    S_CHECK   = 3'd2,
    S_GRANT   = 3'd3,
    S_RELEASE = 3'd4
  } state_t;

  localparam logic             LP_TO_EN    = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] LP_CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t           r_state;
  logic             r_owner;       // 0 = m1, 1 = m2
  logic             r_last_owner;
  logic             r_m1_blocked;
  logic             r_m2_blocked;
  logic [1:0]       r_addr;
  logic [CNT_W-1:0] r_cnt;
  logic             r_m1_grant;
  logic             r_m2_grant;
  logic [1:0]       r_bus_grant;
  logic [1:0]       r_slave_sel;
  logic             r_busy;
  logic             r_addr_err;
  logic             r_timeout;

  logic w_m1_elig;
  logic w_m2_elig;
  logic w_pick_m2;
  logic w_own_req;
  logic w_own_sel;
  logic w_slv_busy;

  // Busy flag of the addressed slave; address 3 has no slave and reads as idle.
  function automatic logic slave_is_busy(input logic [2:0] busy, input logic [1:0] addr);
    logic res;
    case (addr)
      2'd0:    res = busy[0];
      2'd1:    res = busy[1];
      2'd2:    res = busy[2];
      default: res = 1'b0;
    endcase
    return res;
  endfunction

  // Arbitration and owner-side input selection.
  always_comb begin
    w_m1_elig  = m1_request & ~r_m1_blocked;
    w_m2_elig  = m2_request & ~r_m2_blocked;
    if (w_m1_elig && w_m2_elig) begin
      w_pick_m2 = ~r_last_owner;
    end else begin
      w_pick_m2 = w_m2_elig;
    end
    w_own_req  = r_owner ? m2_request : m1_request;
    w_own_sel  = r_owner ? m2_slave_sel : m1_slave_sel;
    w_slv_busy = slave_is_busy(slave_busy, r_addr);
  end

  // Sequencer FSM with registered grant and status outputs.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst) begin
      r_state      <= S_IDLE;
      r_owner      <= 1'b0;
      r_last_owner <= 1'b1;
      r_m1_blocked <= 1'b0;
      r_m2_blocked <= 1'b0;
      r_addr       <= 2'd0;
      r_cnt        <= '0;
      r_m1_grant   <= 1'b0;
      r_m2_grant   <= 1'b0;
      r_bus_grant  <= 2'd0;
      r_slave_sel  <= 2'd0;
      r_busy       <= 1'b0;
      r_addr_err   <= 1'b0;
      r_timeout    <= 1'b0;
    end else begin
      r_addr_err <= 1'b0;
      r_timeout  <= 1'b0;
      if (!m1_request) r_m1_blocked <= 1'b0;
      if (!m2_request) r_m2_blocked <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_m1_elig || w_m2_elig) begin
            r_owner   <= w_pick_m2;
            r_addr[1] <= w_pick_m2 ? m2_slave_sel : m1_slave_sel;
            r_busy    <= 1'b1;
            r_state   <= S_ADDR_LO;
          end
        end
        S_ADDR_LO: begin
          r_addr[0] <= w_own_sel;
          r_state   <= S_CHECK;
        end
        S_CHECK: begin
          if (r_addr == 2'd3) begin
            r_addr_err   <= 1'b1;
            r_last_owner <= r_owner;
            r_state      <= S_RELEASE;
          end else if (!w_own_req) begin
            r_state <= S_RELEASE;
          end else if (w_slv_busy) begin
            r_state <= S_CHECK;
          end else begin
            r_m1_grant  <= ~r_owner;
            r_m2_grant  <= r_owner;
            r_bus_grant <= r_owner ? 2'd2 : 2'd1;
            r_slave_sel <= r_addr;
            r_cnt       <= '0;
            r_state     <= S_GRANT;
          end
        end
        S_GRANT: begin
          r_cnt <= r_cnt + CNT_W'(1);
          if (!w_own_req || (LP_TO_EN && (r_cnt == LP_CNT_LAST))) begin
            r_m1_grant  <= 1'b0;
            r_m2_grant  <= 1'b0;
            r_bus_grant <= 2'd0;
            r_slave_sel <= 2'd0;
            r_state     <= S_RELEASE;
            if (w_own_req) begin
              r_timeout <= 1'b1;
              if (r_owner) r_m2_blocked <= 1'b1;
              else         r_m1_blocked <= 1'b1;
            end
          end
        end
        S_RELEASE: begin
          r_last_owner <= r_owner;
          r_busy       <= 1'b0;
          r_state      <= S_IDLE;
        end
        default: begin
          r_m1_grant  <= 1'b0;
          r_m2_grant  <= 1'b0;
          r_bus_grant <= 2'd0;
          r_slave_sel <= 2'd0;
          r_busy      <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign m1_grant     = r_m1_grant;
  assign m2_grant     = r_m2_grant;
  assign bus_grant    = r_bus_grant;
  assign slave_sel    = r_slave_sel;
  assign arbiter_busy = r_busy;
  assign addr_err     = r_addr_err;
  assign timeout      = r_timeout;

endmodule
